// File: rtl/gpio_bank_pkg.sv
// Shared register map and pad mode encodings for the GPIO bank.
package gpio_bank_pkg;

    localparam logic [31:0] OFF_CTRL_LO    = 32'h00;
    localparam logic [31:0] OFF_CTRL_HI    = 32'h04;
    localparam logic [31:0] OFF_DATA       = 32'h08;
    localparam logic [31:0] OFF_RISE_EN    = 32'h0C;
    localparam logic [31:0] OFF_FALL_EN    = 32'h10;
    localparam logic [31:0] OFF_IRQ_STATUS = 32'h14;

    typedef enum logic [1:0] {
        MODE_INPUT     = 2'b00,
        MODE_PUSH_PULL = 2'b01,
        MODE_OPEN_DRN  = 2'b10,
        MODE_RESERVED  = 2'b11
    } gpio_mode_e;

    // Word index as decoded from addr[4:2].
    function automatic logic [2:0] reg_idx(input logic [31:0] off);
        return off[4:2];
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop input synchronizer, WIDTH bits wide and STAGES flops deep.
module gpio_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-pin mode control, data, synchronized inputs.
// Edge interrupts are built only when GPIO_IRQ_EN is defined.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned N_PINS      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic [N_PINS-1:0] io_pin_i,
    output logic [N_PINS-1:0] io_pin_o,
    output logic [N_PINS-1:0] io_oe_o,
    output logic              int_o
);

    logic [2*N_PINS-1:0] ctrl_q, ctrl_d;
    logic [N_PINS-1:0]   data_q, data_d;
    logic [N_PINS-1:0]   pin_sync;
    logic [N_PINS-1:0]   data_rd;
    logic [31:0]         ctrl_lo_rd, ctrl_hi_rd;
    logic [2:0]          idx;
    logic                unused_bus_bits;

    assign idx             = addr_i[4:2];
    assign unused_bus_bits = ^{addr_i[31:5], addr_i[1:0], data_i};

    gpio_sync #(
        .WIDTH  (N_PINS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (io_pin_i),
        .q_o (pin_sync)
    );

    // Pins 0-15 map to CTRL_LO, 16-31 to CTRL_HI, two bits each.
    always_comb begin
        ctrl_d     = ctrl_q;
        data_d     = data_q;
        ctrl_lo_rd = '0;
        ctrl_hi_rd = '0;
        for (int unsigned i = 0; i < N_PINS; i++) begin
            if (i < 16) begin
                ctrl_lo_rd[2*(i%16) +: 2] = ctrl_q[2*i +: 2];
                if (we_i && idx == reg_idx(OFF_CTRL_LO))
                    ctrl_d[2*i +: 2] = data_i[2*(i%16) +: 2];
            end else begin
                ctrl_hi_rd[2*(i%16) +: 2] = ctrl_q[2*i +: 2];
                if (we_i && idx == reg_idx(OFF_CTRL_HI))
                    ctrl_d[2*i +: 2] = data_i[2*(i%16) +: 2];
            end
        end
        if (we_i && idx == reg_idx(OFF_DATA))
            data_d = data_i[N_PINS-1:0];
    end

    always_comb begin
        io_oe_o  = '0;
        io_pin_o = '0;
        data_rd  = '0;
        for (int unsigned i = 0; i < N_PINS; i++) begin
            case (ctrl_q[2*i +: 2])
                MODE_PUSH_PULL: begin
                    io_oe_o[i]  = 1'b1;
                    io_pin_o[i] = data_q[i];
                    data_rd[i]  = data_q[i];
                end
                MODE_OPEN_DRN: begin
                    io_oe_o[i]  = ~data_q[i];
                    data_rd[i]  = data_q[i];
                end
                default: data_rd[i] = pin_sync[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [N_PINS-1:0] rise_en_q, rise_en_d;
    logic [N_PINS-1:0] fall_en_q, fall_en_d;
    logic [N_PINS-1:0] irq_q, irq_d;
    logic [N_PINS-1:0] hist_q, hist_d;
    logic              int_q, int_d;
    logic [N_PINS-1:0] edge_hit;

    // New edges are OR'd in after the W1C so a coincident edge keeps the bit set.
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        hist_d    = pin_sync;
        edge_hit  = (pin_sync & ~hist_q & rise_en_q) | (~pin_sync & hist_q & fall_en_q);
        irq_d     = irq_q;
        if (we_i && idx == reg_idx(OFF_RISE_EN))    rise_en_d = data_i[N_PINS-1:0];
        if (we_i && idx == reg_idx(OFF_FALL_EN))    fall_en_d = data_i[N_PINS-1:0];
        if (we_i && idx == reg_idx(OFF_IRQ_STATUS)) irq_d = irq_q & ~data_i[N_PINS-1:0];
        irq_d = irq_d | edge_hit;
        int_d = |irq_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_q     <= '0;
            hist_q    <= '0;
            int_q     <= 1'b0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_q     <= irq_d;
            hist_q    <= hist_d;
            int_q     <= int_d;
        end
    end

    assign int_o = int_q;
`else
    assign int_o = 1'b0;
`endif

    always_comb begin
        data_o = '0;
        case (idx)
            reg_idx(OFF_CTRL_LO):    data_o = ctrl_lo_rd;
            reg_idx(OFF_CTRL_HI):    data_o = ctrl_hi_rd;
            reg_idx(OFF_DATA):       data_o[N_PINS-1:0] = data_rd;
`ifdef GPIO_IRQ_EN
            reg_idx(OFF_RISE_EN):    data_o[N_PINS-1:0] = rise_en_q;
            reg_idx(OFF_FALL_EN):    data_o[N_PINS-1:0] = fall_en_q;
            reg_idx(OFF_IRQ_STATUS): data_o[N_PINS-1:0] = irq_q;
`endif
            default:                 data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (N_PINS=20); expectations follow GPIO_IRQ_EN.
module tb_gpio_bank;

    localparam int unsigned NP = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          we_i;
    logic [31:0]   addr_i;
    logic [31:0]   data_i;
    logic [31:0]   data_o;
    logic [NP-1:0] io_pin_i;
    logic [NP-1:0] io_pin_o;
    logic [NP-1:0] io_oe_o;
    logic          int_o;

    int checks = 0;
    int errors = 0;

    gpio_bank #(
        .N_PINS      (NP),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .io_pin_i (io_pin_i),
        .io_pin_o (io_pin_o),
        .io_oe_o  (io_oe_o),
        .int_o    (int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        @(negedge clk);
        we_i   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_i = a;
        #1;
        check(tag, data_o, exp);
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0; io_pin_i = '0;
        #12;
        check("rst_oe",  {12'h0, io_oe_o},  32'h0);
        check("rst_pin", {12'h0, io_pin_o}, 32'h0);
        check("rst_int", {31'h0, int_o},    32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_oe", {12'h0, io_oe_o}, 32'h0);
        rd("rst_ctrl_lo", 32'h00, 32'h0);
        rd("rst_data",    32'h08, 32'h0);
        rd("rst_irq",     32'h14, 32'h0);

        // push-pull pin 0
        wr(32'h00, 32'h0000_0001);
        wr(32'h08, 32'h0000_0001);
        check("pp_oe",  {12'h0, io_oe_o},  32'h1);
        check("pp_pin", {12'h0, io_pin_o}, 32'h1);
        rd("pp_data_rd", 32'h08, 32'h1);

        // open-drain pin 3
        wr(32'h00, 32'h0000_0081);
        check("od_lo_oe",  {12'h0, io_oe_o},  32'h9);
        check("od_lo_pin", {12'h0, io_pin_o}, 32'h1);
        wr(32'h08, 32'h0000_0009);
        check("od_hi_oe",  {12'h0, io_oe_o},  32'h1);
        check("od_hi_pin", {12'h0, io_pin_o}, 32'h1);

        // input pin 7 and reserved-mode pin 8 read the synchronized pad
        wr(32'h00, 32'h0003_0081);
        io_pin_i[7] = 1'b1;
        io_pin_i[8] = 1'b1;
        repeat (3) @(negedge clk);
        rd("in_data_rd", 32'h08, 32'h0000_0189);
        io_pin_i[7] = 1'b0;
        io_pin_i[8] = 1'b0;

        // CTRL bits beyond pin 19 and unmapped slots
        wr(32'h04, 32'hFFFF_FFFF);
        rd("ctrl_hi_rd", 32'h04, 32'h0000_00FF);
        rd("ctrl_lo_keep", 32'h00, 32'h0003_0081);
        wr(32'h18, 32'hFFFF_FFFF);
        rd("slot6_rd", 32'h18, 32'h0);
        rd("slot7_rd", 32'h1C, 32'h0);

        // all 20 pins push-pull; DATA above pin 19 is dropped
        wr(32'h00, 32'h5555_5555);
        wr(32'h04, 32'h5555_5555);
        rd("ctrl_hi_pp", 32'h04, 32'h0000_0055);
        wr(32'h08, 32'hFFFF_FFFF);
        rd("data_all", 32'h08, 32'h000F_FFFF);
        check("oe_all",  {12'h0, io_oe_o},  32'h000F_FFFF);
        check("pin_all", {12'h0, io_pin_o}, 32'h000F_FFFF);
        wr(32'h04, 32'h0);
        wr(32'h00, 32'h0000_0001);
        wr(32'h08, 32'h0000_0001);

`ifdef GPIO_IRQ_EN
        wr(32'h0C, 32'h0000_0020);
        rd("rise_en_rd", 32'h0C, 32'h0000_0020);
        @(negedge clk);
        io_pin_i[5] = 1'b1;
        repeat (2) @(negedge clk);
        rd("irq_edge2", 32'h14, 32'h0);
        @(negedge clk);
        rd("irq_edge3", 32'h14, 32'h0000_0020);
        check("int_edge3", {31'h0, int_o}, 32'h0);
        @(negedge clk);
        check("int_edge4", {31'h0, int_o}, 32'h1);

        wr(32'h14, 32'h0);
        rd("w1c_zero", 32'h14, 32'h0000_0020);
        wr(32'h14, 32'h0000_0020);
        rd("w1c_clear", 32'h14, 32'h0);
        @(negedge clk);
        check("int_clear", {31'h0, int_o}, 32'h0);

        // falling edge while FALL_EN=0, then enabling must not set status
        io_pin_i[5] = 1'b0;
        repeat (4) @(negedge clk);
        wr(32'h10, 32'h0000_0020);
        repeat (2) @(negedge clk);
        rd("no_retro", 32'h14, 32'h0);
        wr(32'h10, 32'h0);

        // W1C lands on the same edge that records a new rise
        io_pin_i[5] = 1'b1;
        repeat (2) @(negedge clk);
        we_i = 1'b1; addr_i = 32'h14; data_i = 32'h0000_0020;
        @(negedge clk);
        we_i = 1'b0;
        rd("set_wins", 32'h14, 32'h0000_0020);
        @(negedge clk);
        check("int_set_wins", {31'h0, int_o}, 32'h1);
`else
        wr(32'h0C, 32'h0000_0020);
        rd("rise_en_off", 32'h0C, 32'h0);
        wr(32'h10, 32'h0000_0020);
        rd("fall_en_off", 32'h10, 32'h0);
        @(negedge clk);
        io_pin_i[5] = 1'b1;
        repeat (4) @(negedge clk);
        rd("irq_off", 32'h14, 32'h0);
        check("int_off", {31'h0, int_o}, 32'h0);
`endif

        // reset mid-interrupt with pin 5 held high through release
        #2;
        rst = 1'b1;
        #1;
        check("midrst_oe",  {12'h0, io_oe_o}, 32'h0);
        check("midrst_int", {31'h0, int_o},   32'h0);
        rd("midrst_irq", 32'h14, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rd("rel_irq", 32'h14, 32'h0);
        check("rel_int", {31'h0, int_o}, 32'h0);
        rd("rel_data", 32'h08, 32'h0000_0020);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL have parameter N_PINS, default 16, meaning the number of pins (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the input synchronizer depth (legal range 2..4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port we_i, input, 1 bit: bus write strobe.
REQ-006 SHALL have port addr_i, input, 32 bits: bus address; only bits [4:2] are decoded.
REQ-007 SHALL have port data_i, input, 32 bits: bus write data.
REQ-008 SHALL have port data_o, output, 32 bits: bus read data.
REQ-009 SHALL have port io_pin_i, input, N_PINS bits: raw pad inputs.
REQ-010 SHALL have port io_pin_o, output, N_PINS bits: pad output values.
REQ-011 SHALL have port io_oe_o, output, N_PINS bits: pad output enables (1 = drive).
REQ-012 SHALL have port int_o, output, 1 bit: level interrupt.

Function
REQ-013 SHALL provide these registers, selected by addr_i[4:2]:
- 0 CTRL_LO: pins 0-15, 2 bits each.
- 1 CTRL_HI: pins 16-31, 2 bits each.
- 2 DATA.
- 3 RISE_EN.
- 4 FALL_EN.
- 5 IRQ_STATUS.
- 6-7: read 0, writes ignored.
REQ-014 SHALL apply writes on the clk edge on which we_i=1.
REQ-015 SHALL drive data_o combinationally from the current register state (zero-latency read).
REQ-016 SHALL decode the CTRL mode per pin:
- 00 input: io_oe_o=0.
- 01 push-pull: io_oe_o=1, io_pin_o=DATA bit.
- 10 open-drain: io_oe_o=~DATA bit, io_pin_o=0.
- 11 reserved: treated as input.
REQ-017 SHALL return, on a DATA read, the DATA register bit for pins in mode 01/10 and the synchronized input for pins in mode 00/11.
REQ-018 SHALL pass each io_pin_i bit through a SYNC_STAGES-flop synchronizer, followed by one history flop used for edge detection.
REQ-019 SHALL set an IRQ_STATUS bit on a synchronized 0->1 transition when the pin's RISE_EN bit is 1, and on a 1->0 transition when its FALL_EN bit is 1.
REQ-020 SHALL set the IRQ_STATUS bit SYNC_STAGES+1 clk edges after the io_pin_i transition is sampled.
REQ-021 SHALL clear IRQ_STATUS bits by write-1-to-clear; writing 0 has no effect.
REQ-022 SHALL let set win when a new edge and a W1C of the same bit occur in the same cycle.
REQ-023 SHALL drive int_o registered as the OR of IRQ_STATUS, i.e. one cycle after the status bit sets.
REQ-024 SHALL ignore edges on pins whose enable bit is 0; a later enable does not retroactively set status.
REQ-025 SHALL read register bits at or above N_PINS (and CTRL bits beyond pin N_PINS-1) as 0 and ignore writes to them.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear all registers, synchronizer flops and history flops to 0.
REQ-027 SHALL hold io_oe_o=0, io_pin_o=0 and int_o=0 during and immediately after reset.
REQ-028 SHALL set no IRQ_STATUS bit for a pin held high through reset release, because RISE_EN is 0 after reset.

Configuration
REQ-029 SHALL compile the interrupt logic in only when macro GPIO_IRQ_EN is defined.
- Defined: REQ-019..024 apply.
- Undefined: RISE_EN, FALL_EN and IRQ_STATUS read 0 and ignore writes; int_o is tied 0; the history flop is removed.

Structure
REQ-030 SHALL place register offsets (0x00..0x14) and mode encodings (00/01/10/11) in the shared defines file, not in the module.
REQ-031 SHALL implement the synchronizer as sub-module gpio_sync, parameterised by WIDTH and STAGES, and instantiated once with WIDTH=N_PINS.

Verification
REQ-032 SHALL cover: write CTRL_LO=0x0000_0001 and DATA=0x1 -> io_oe_o[0]=1, io_pin_o[0]=1 on the next cycle.
REQ-033 SHALL cover: set CTRL_LO pin 3 to 10 and DATA bit3=0 -> io_oe_o[3]=1, io_pin_o[3]=0; then DATA bit3=1 -> io_oe_o[3]=0.
REQ-034 SHALL cover: RISE_EN=0x0020, raise io_pin_i[5] -> IRQ_STATUS=0x0020 after 3 edges and int_o=1 one cycle later.
REQ-035 SHALL cover: write IRQ_STATUS=0x0020 in the same cycle as a new detected edge on pin 5 -> bit stays 1.
REQ-036 SHALL cover: assert rst mid-interrupt -> IRQ_STATUS=0, int_o=0, io_oe_o=0 immediately; with io_pin_i high at reset release -> no status set.
REQ-037 SHALL cover: N_PINS=20, write CTRL_HI=0xFFFF_FFFF -> read back 0x0000_00FF; with GPIO_IRQ_EN undefined, IRQ_STATUS reads 0.
